// File: rtl/multi_nibble_alu_seq.sv
// Multi-nibble add/subtract sequencer for a shared 4-bit arithmetic unit.
// Each clock it presents one nibble of the latched operands to the unit,
// starting with the least significant nibble. The carry or borrow that comes
// back is stored in a register and used for the next nibble. When every
// nibble is done, it raises a one-cycle done pulse and holds the full-width
// result, carry/borrow and signed-overflow flag until the next op is accepted.
//
//    state  | meaning
//    IDLE   | ready high, unit opcode idle, waiting for start
//    RUN    | one nibble per clock through the external unit, LSB first
//    DONE   | one-cycle done pulse, then back to IDLE
module multi_nibble_alu_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic                   cin,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   output logic                   ready,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf,
   output logic [1:0]             au_op,
   output logic [3:0]             au_a,
   output logic [3:0]             au_b,
   output logic                   au_cin,
   input  logic [3:0]             au_add_y,
   input  logic [3:0]             au_sub_y,
   input  logic                   au_cout,
   input  logic                   au_ovf
);

   localparam int WIDTH = 4 * NIBBLES;
   localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_IDLE = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   logic [1:0]       state;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic             op_lat;

   logic [3:0] nib_y;
   logic       a_msb;
   logic       b_msb;
   logic       ovf_next;

   // The unit computes both paths at once, and its own overflow output only
   // covers the add path. Full-width overflow is derived locally instead.
   logic unused_inputs;
   assign unused_inputs = au_ovf;

   // Combinational view of the unit result and the overflow on the final nibble
   always_comb begin
      nib_y    = op_lat ? au_sub_y : au_add_y;
      a_msb    = a_lat[WIDTH-1];
      b_msb    = b_lat[WIDTH-1];
      ovf_next = 1'b0;
      if (op_lat)
         ovf_next = (a_msb != b_msb) && (nib_y[3] != a_msb);
      else
         ovf_next = (a_msb == b_msb) && (nib_y[3] != a_msb);
   end

   // Drive the unit and the handshake outputs from the registered state
   always_comb begin
      ready  = (state == S_IDLE);
      done   = (state == S_DONE);
      au_op  = OP_IDLE;
      au_a   = 4'd0;
      au_b   = 4'd0;
      au_cin = carry;
      if (state == S_RUN) begin
         au_op = op_lat ? OP_SUB : OP_ADD;
         au_a  = a_lat[{idx, 2'b00} +: 4];
         au_b  = b_lat[{idx, 2'b00} +: 4];
      end
   end

   // Sequencer state, operand latches and nibble-by-nibble result accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         a_lat  <= '0;
         b_lat  <= '0;
         op_lat <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_lat  <= a_in;
                  b_lat  <= b_in;
                  op_lat <= op_sub;
                  carry  <= cin;
                  idx    <= '0;
                  result <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               result[{idx, 2'b00} +: 4] <= nib_y;
               carry <= au_cout;
               if (idx == IDX_LAST) begin
                  cout  <= au_cout;
                  ovf   <= ovf_next;
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_nibble_alu_seq.sv
// Bench for multi_nibble_alu_seq. It models the external 4-bit unit and keeps
// a scoreboard of full-width expected results. A monitor pops the scoreboard
// on every done pulse and compares the popped entry with the DUT outputs.
module tb_multi_nibble_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op_sub;
   logic        cin;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        ready;
   logic        done;
   logic [15:0] result;
   logic        cout;
   logic        ovf;
   logic [1:0]  au_op;
   logic [3:0]  au_a;
   logic [3:0]  au_b;
   logic        au_cin;
   logic [3:0]  au_add_y;
   logic [3:0]  au_sub_y;
   logic        au_cout;
   logic        au_ovf;

   multi_nibble_alu_seq #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
      .a_in(a_in), .b_in(b_in), .ready(ready), .done(done), .result(result),
      .cout(cout), .ovf(ovf), .au_op(au_op), .au_a(au_a), .au_b(au_b),
      .au_cin(au_cin), .au_add_y(au_add_y), .au_sub_y(au_sub_y),
      .au_cout(au_cout), .au_ovf(au_ovf)
   );

   always #5 clk = ~clk;

   // 4-bit arithmetic unit model
   logic [4:0] add_full;
   logic [4:0] sub_full;
   assign add_full = 5'(au_a) + 5'(au_b) + 5'(au_cin);
   assign sub_full = 5'(au_a) - 5'(au_b) - 5'(au_cin);
   assign au_add_y = add_full[3:0];
   assign au_sub_y = sub_full[3:0];
   assign au_cout  = (au_op == 2'b01) ? add_full[4] :
                     (au_op == 2'b10) ? sub_full[4] : 1'b0;
   assign au_ovf   = (au_op == 2'b01) &&
                     (au_a[3] == au_b[3]) && (add_full[3] != au_a[3]);

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_done   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic ci);
      exp_t e;
      logic [16:0] s;
      if (sub) s = {1'b0, a} - {1'b0, b} - 17'(ci);
      else     s = {1'b0, a} + {1'b0, b} + 17'(ci);
      e.r = s[15:0];
      e.c = s[16];
      if (sub) e.v = (a[15] != b[15]) && (s[15] != a[15]);
      else     e.v = (a[15] == b[15]) && (s[15] != a[15]);
      return e;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest pending op
   always @(negedge clk) begin
      if (au_op == 2'b11) check("au_op_never_11", 32'(au_op), 32'd0);
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.r));
            check("cout",   32'(cout),   32'(e.c));
            check("ovf",    32'(ovf),    32'(e.v));
         end
      end
   end

   // Launch one op from IDLE and follow it to the cycle where ready returns.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic ci, input bit spam);
      int lat;
      int opcnt;
      int done_before;
      logic [15:0] av;
      logic [15:0] bv;
      logic [1:0]  opv;
      exp_t e;
      av = a;
      bv = b;
      opv = sub ? 2'b10 : 2'b01;
      lat = 0;
      opcnt = 0;
      @(negedge clk);
      check("ready_before_start", 32'(ready), 32'd1);
      done_before = n_done;
      start = 1'b1; a_in = a; b_in = b; op_sub = sub; cin = ci;
      e = model(a, b, sub, ci);
      sb.push_back(e);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (spam) begin
            start  = 1'b1;
            a_in   = 16'($urandom);
            b_in   = 16'($urandom);
            op_sub = 1'($urandom);
            cin    = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         if (done && lat == 0) lat = n;
         if (au_op == opv) opcnt++;
         if (n <= 4) begin
            check("au_a_nibble", 32'(au_a), 32'(av[4*(n-1) +: 4]));
            check("au_b_nibble", 32'(au_b), 32'(bv[4*(n-1) +: 4]));
         end
      end
      start = 1'b0;
      check("done_latency", 32'(lat), 32'd5);
      check("au_op_active_cycles", 32'(opcnt), 32'd4);
      check("ready_returns", 32'(ready), 32'd1);
      check("result_held_idle", 32'(result), 32'(e.r));
      if (spam) begin
         repeat (7) @(negedge clk);
         check("result_after_spam", 32'(result), 32'(e.r));
         check("ready_after_spam", 32'(ready), 32'd1);
      end
      check("one_done_per_op", 32'(n_done - done_before), 32'd1);
   endtask

   initial begin
      int done_before;
      rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0;
      a_in = 16'h0; b_in = 16'h0;
      repeat (2) @(negedge clk);
      check("rst_ready",  32'(ready),  32'd1);
      check("rst_done",   32'(done),   32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout",   32'(cout),   32'd0);
      check("rst_ovf",    32'(ovf),    32'd0);
      check("rst_au_op",  32'(au_op),  32'd0);
      check("rst_au_a",   32'(au_a),   32'd0);
      check("rst_au_b",   32'(au_b),   32'd0);
      check("rst_au_cin", 32'(au_cin), 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
      check("add_1234_0fcd", 32'(result), 32'h2201);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("add_ovf_flag", 32'(ovf), 32'd1);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("add_carry_flag", 32'(cout), 32'd1);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
      check("add_cin", 32'(result), 32'h0003);
      run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
      check("sub_borrow_result", 32'(result), 32'hFFFF);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
      check("sub_ovf_result", 32'(result), 32'h7FFF);
      run_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b1);
      run_op(16'h4E21, 16'hB1DE, 1'b0, 1'b1, 1'b0);

      // Abort during the second RUN cycle after an op that left cout=1
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      done_before = n_done;
      start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; op_sub = 1'b0; cin = 1'b0;
      sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_in_run", 32'(au_op), 32'b01);
      rst = 1'b1;
      @(negedge clk);
      void'(sb.pop_back());
      rst = 1'b0;
      check("abort_ready",  32'(ready),  32'd1);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout",   32'(cout),   32'd0);
      check("abort_done",   32'(done),   32'd0);
      check("abort_au_op",  32'(au_op),  32'd0);
      repeat (6) @(negedge clk);
      check("abort_no_done", 32'(n_done - done_before), 32'd0);
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
      check("after_abort_add", 32'(result), 32'h1000);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
